// File: rtl/strobe_pkg.sv
`default_nettype none
// ============================================================================
// Module : strobe_pkg
// Brief  : Shared types and defaults for the decimation strobe rate checker.
// Rev    : 1.0  initial release
// ============================================================================
package strobe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_ERRW  = 16;

  // Rates are encoded as divide ratio minus 1 (strobe on every strobe_in -> 0).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/strobe_rate_check_if.sv
`default_nettype none
// ============================================================================
// Module : strobe_rate_check_if
// Brief  : Strobe stimulus and status bundle between a source and the checker.
// Rev    : 1.0  initial release
// ============================================================================
interface strobe_rate_check_if #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 16
);
  logic             enable;
  logic             strobe_in;
  logic             strobe;
  logic [WIDTH-1:0] expected_rate;
  logic [WIDTH-1:0] measured_rate;
  logic             measured_valid;
  logic             locked;
  logic             rate_error;
  logic             timeout;
  logic [ERRW-1:0]  err_count;

  modport master (
    output enable, strobe_in, strobe, expected_rate,
    input  measured_rate, measured_valid, locked, rate_error, timeout, err_count
  );

  modport slave (
    input  enable, strobe_in, strobe, expected_rate,
    output measured_rate, measured_valid, locked, rate_error, timeout, err_count
  );
endinterface
`default_nettype wire

// File: rtl/strobe_rate_check_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up counter that sticks at MAX, with a synchronous active-low clear.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         clr_n,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!clr_n) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/strobe_rate_check.sv
`default_nettype none
// ============================================================================
// Module : strobe_rate_check
// Brief  : Measures the delivered strobe divide ratio and reports lock/errors.
// Rev    : 1.0  initial release
// ============================================================================
module strobe_rate_check
  import strobe_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int ERRW       = DEFAULT_ERRW
) (
  input wire logic          clock,
  input wire logic          reset,
  strobe_rate_check_if.slave bus
);

  localparam int               RUNW    = 4;
  localparam logic [RUNW-1:0]  RUN_MAX = RUNW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] meas_q, meas_d;
  logic             mvalid_q, mvalid_d;
  logic             locked_q, locked_d;
  logic             rerr_q, rerr_d;
  logic             tout_q, tout_d;

  logic [RUNW-1:0]  run;
  logic             run_inc;
  logic             run_clr_n;
  logic             err_inc;
  logic [ERRW-1:0]  err_cnt;

  logic w_valid, w_illegal, w_tick, w_match, w_lock_hit;

  assign w_valid    = bus.strobe & bus.strobe_in;
  assign w_illegal  = bus.strobe & ~bus.strobe_in;
  assign w_tick     = bus.strobe_in & ~bus.strobe;
  assign w_match    = (cnt_q == bus.expected_rate);
  assign w_lock_hit = ((int'(run) + 1) >= LOCK_COUNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_d    = meas_q;
    mvalid_d  = 1'b0;
    locked_d  = locked_q;
    rerr_d    = 1'b0;
    tout_d    = 1'b0;
    run_inc   = 1'b0;
    run_clr_n = 1'b1;
    err_inc   = 1'b0;

    if (!bus.enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      locked_d  = 1'b0;
      run_clr_n = 1'b0;
    end else if (w_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: state_d = ST_MEASURE;
        ST_MEASURE, ST_TRACK: begin
          meas_d   = cnt_q;
          mvalid_d = 1'b1;
          state_d  = ST_TRACK;
          if (w_match) begin
            run_inc = 1'b1;
            if (w_lock_hit) locked_d = 1'b1;
          end else begin
            run_clr_n = 1'b0;
            // The first interval after phase acquisition is never an error.
            if (state_q == ST_TRACK) begin
              locked_d = 1'b0;
              rerr_d   = 1'b1;
              err_inc  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (w_tick) begin
      if ((state_q != ST_IDLE) && (cnt_q == CNT_MAX)) begin
        tout_d    = 1'b1;
        locked_d  = 1'b0;
        run_clr_n = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (w_illegal) begin
      rerr_d    = 1'b1;
      err_inc   = 1'b1;
      locked_d  = 1'b0;
      run_clr_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      meas_q   <= '0;
      mvalid_q <= 1'b0;
      locked_q <= 1'b0;
      rerr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      mvalid_q <= mvalid_d;
      locked_q <= locked_d;
      rerr_q   <= rerr_d;
      tout_q   <= tout_d;
    end
  end

  sat_counter #(.W(RUNW), .MAX(RUN_MAX)) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .clr_n (run_clr_n),
    .inc   (run_inc),
    .count (run)
  );

  sat_counter #(.W(ERRW)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .clr_n (1'b1),
    .inc   (err_inc),
    .count (err_cnt)
  );

  assign bus.measured_rate  = meas_q;
  assign bus.measured_valid = mvalid_q;
  assign bus.locked         = locked_q;
  assign bus.rate_error     = rerr_q;
  assign bus.timeout        = tout_q;
  assign bus.err_count      = err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_strobe_rate_check.sv
`default_nettype none
// ============================================================================
// Module : tb_strobe_rate_check
// Brief  : Directed and randomized bench against an interval-based reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_strobe_rate_check;

  localparam int WIDTH   = 8;
  localparam int LOCKN   = 4;
  localparam int ERRW    = 16;
  localparam int CNT_TOP = 255;
  localparam int ERR_TOP = 65535;

  logic clock;
  logic reset;

  strobe_rate_check_if #(.WIDTH(WIDTH), .ERRW(ERRW)) bus ();

  strobe_rate_check #(.WIDTH(WIDTH), .LOCK_COUNT(LOCKN), .ERRW(ERRW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: phase reference flag, strobe_in ticks since last valid
  // strobe, measurements taken since phase, and a run of matching intervals.
  bit m_phase;
  int m_since, m_nmeas, m_streak, m_rate, m_errs;
  bit m_lock, m_mv, m_err, m_to;
  int n_timeouts;

  task automatic model_step(input bit rst_n, input bit en, input bit si, input bit st, input int er);
    m_mv = 0; m_err = 0; m_to = 0;
    if (!rst_n) begin
      m_phase = 0; m_since = 0; m_nmeas = 0; m_streak = 0;
      m_lock = 0; m_rate = 0; m_errs = 0;
    end else if (!en) begin
      m_phase = 0; m_since = 0; m_streak = 0; m_lock = 0;
    end else if (st && si) begin
      if (m_phase) begin
        m_rate = m_since;
        m_mv   = 1;
        if (m_since == er) begin
          m_streak = (m_streak + 1 > LOCKN) ? LOCKN : m_streak + 1;
          if (m_streak == LOCKN) m_lock = 1;
        end else begin
          m_streak = 0;
          if (m_nmeas > 0) begin
            m_lock = 0; m_err = 1;
            if (m_errs < ERR_TOP) m_errs++;
          end
        end
        m_nmeas++;
      end else begin
        m_phase = 1;
        m_nmeas = 0;
      end
      m_since = 0;
    end else if (si) begin
      if (m_phase && m_since == CNT_TOP) begin
        m_to = 1; m_lock = 0; m_streak = 0; m_since = 0; m_phase = 0;
      end else if (m_since < CNT_TOP) begin
        m_since++;
      end
    end else if (st) begin
      m_err = 1; m_lock = 0; m_streak = 0;
      if (m_errs < ERR_TOP) m_errs++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit si, input bit st, input int er);
    bus.enable        = en;
    bus.strobe_in     = si;
    bus.strobe        = st;
    bus.expected_rate = WIDTH'(er);
    @(posedge clock);
    model_step(reset, en, si, st, er);
    #1;
    if (bus.timeout === 1'b1) n_timeouts++;
    chk("measured_rate",  32'(bus.measured_rate), 32'(m_rate));
    chk("measured_valid", 32'(bus.measured_valid), 32'(m_mv));
    chk("locked",         32'(bus.locked), 32'(m_lock));
    chk("rate_error",     32'(bus.rate_error), 32'(m_err));
    chk("timeout",        32'(bus.timeout), 32'(m_to));
    chk("err_count",      32'(bus.err_count), 32'(m_errs));
  endtask

  initial begin
    int k;
    int r;
    bit si, st, en;

    n_timeouts = 0;
    reset = 1'b0;
    bus.enable = 1'b0; bus.strobe_in = 1'b0; bus.strobe = 1'b0; bus.expected_rate = '0;

    // Reset state
    repeat (3) cyc(1, 1, 1, 3);
    reset = 1'b1;

    // Rate 3, strobe every 4th cycle; lock after the 5th strobe
    for (int i = 0; i < 20; i++) cyc(1, 1, (i % 4) == 0, 3);
    chk("lock_after_5_strobes", 32'(bus.locked), 32'd1);
    chk("rate3_measured", 32'(bus.measured_rate), 32'd3);

    // One long interval of 6, then relock
    for (int i = 0; i < 6; i++) cyc(1, 1, i == 0, 3);
    cyc(1, 1, 1, 3);
    chk("long_interval_rate", 32'(bus.measured_rate), 32'd5);
    chk("long_interval_unlock", 32'(bus.locked), 32'd0);
    chk("long_interval_errs", 32'(bus.err_count), 32'd1);
    for (int i = 1; i < 17; i++) cyc(1, 1, (i % 4) == 0, 3);
    chk("relock", 32'(bus.locked), 32'd1);

    // Illegal strobe mid-interval while locked
    cyc(1, 1, 0, 3);
    cyc(1, 0, 1, 3);
    chk("illegal_unlock", 32'(bus.locked), 32'd0);
    chk("illegal_errs", 32'(bus.err_count), 32'd2);
    cyc(1, 1, 0, 3);
    cyc(1, 1, 0, 3);
    cyc(1, 1, 1, 3);
    chk("illegal_cnt_undisturbed", 32'(bus.measured_rate), 32'd3);

    // Rate 0: strobe on every strobe_in
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0);
    chk("rate0_locked", 32'(bus.locked), 32'd1);

    // Timeout: strobe_in every 3rd cycle, strobe every 3rd strobe_in
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 1, 2);
      cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 0, 2);
      cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 0, 2);
    end
    cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 1, 2);
    chk("pre_timeout_locked", 32'(bus.locked), 32'd1);
    n_timeouts = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 0, 2);
    end
    chk("no_timeout_at_255", 32'(n_timeouts), 32'd0);
    cyc(1, 0, 0, 2); cyc(1, 0, 0, 2); cyc(1, 1, 0, 2);
    chk("timeout_at_256", 32'(bus.timeout), 32'd1);
    chk("timeout_unlock", 32'(bus.locked), 32'd0);
    cyc(1, 1, 1, 2);
    chk("post_timeout_no_valid", 32'(bus.measured_valid), 32'd0);

    // Randomized segments against the reference
    for (int seg = 0; seg < 30; seg++) begin
      r = $urandom_range(0, 5);
      k = 0;
      for (int i = 0; i < 100; i++) begin
        si = ($urandom_range(0, 3) != 0);
        st = 0;
        if (si) begin
          if (k >= r) begin st = 1; k = 0; end else k++;
          if ($urandom_range(0, 19) == 0) st = ~st;
        end else if ($urandom_range(0, 29) == 0) begin
          st = 1;
        end
        en = ($urandom_range(0, 99) != 0);
        cyc(en, si, st, r);
      end
    end

    // Saturate err_count with illegal strobes
    for (int i = 0; i < 65536; i++) cyc(1, 0, 1, 0);
    chk("err_saturated", 32'(bus.err_count), 32'(ERR_TOP));
    cyc(1, 0, 1, 0);
    chk("err_stays_saturated", 32'(bus.err_count), 32'(ERR_TOP));
    cyc(0, 1, 1, 0);
    chk("disable_unlocked", 32'(bus.locked), 32'd0);
    chk("disable_holds_errs", 32'(bus.err_count), 32'(ERR_TOP));
    reset = 1'b0;
    cyc(1, 1, 1, 0);
    chk("reset_clears_errs", 32'(bus.err_count), 32'd0);
    reset = 1'b1;
    cyc(1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/strobe_rate_check.md
Name: strobe_rate_check

Overview:
- Receive-side checker for the decimation strobe protocol: consumes a divided strobe plus its base-rate qualifier `strobe_in`.
- Measures the divide ratio actually delivered and compares it against the programmed rate.
- Reports lock, mismatch and timeout status.
- Sits beside each decimator/CIC stage in the RX chain, feeding status registers and a debug counter.

Parameters:
- WIDTH, 8: width of rate and interval counters.
- LOCK_COUNT, 4: consecutive matching intervals required to assert `locked` (legal range 1..15).
- ERRW, 16: width of the saturating error counter.

Ports:
- `clock`  input  1  system clock, all logic on posedge.
- `reset`  input  1  synchronous, active-low (0 = reset).
- `enable`  input  1  checker enable; low behaves as a soft clear.
- `strobe_in`  input  1  base-rate qualifier (one pulse per input sample).
- `strobe`  input  1  divided strobe under test; legal only coincident with `strobe_in`.
- `expected_rate`  input  WIDTH  programmed rate, encoded as divide ratio minus 1.
- `measured_rate`  output  WIDTH  last measured interval, same encoding as `expected_rate`.
- `measured_valid`  output  1  one-cycle pulse when `measured_rate` updates.
- `locked`  output  1  LOCK_COUNT consecutive intervals equal to `expected_rate`.
- `rate_error`  output  1  one-cycle pulse on mismatch or illegal strobe.
- `timeout`  output  1  one-cycle pulse when the interval counter saturates.
- `err_count`  output  ERRW  saturating count of `rate_error` events.

Behaviour:
- All outputs are registered. Every event sampled in cycle N is visible in cycle N+1.
- Reset (`reset`==0): state=IDLE; `cnt`=0, `run`=0; all outputs 0, including `err_count`.
- `enable`==0 (with `reset` high):
  - state=IDLE; `cnt`=0, `run`=0, `locked`=0; no pulses.
  - `measured_rate` and `err_count` hold.
- Valid strobe: `strobe` && `strobe_in`. Illegal strobe: `strobe` && !`strobe_in`.
- Interval counter `cnt`:
  - Cleared to 0 on a valid strobe.
  - Incremented on `strobe_in` without `strobe`.
  - Held otherwise.
  - Resulting encoding: a true divide ratio R gives `cnt`=R-1 at the next strobe. Rate 0 (strobe every `strobe_in`) measures 0.
- States:
  - IDLE: wait for the first valid strobe, which only sets phase. Then `cnt`=0 -> MEASURE. No measurement is output.
  - MEASURE: on the next valid strobe, `measured_rate`<=`cnt` and `measured_valid` pulses.
    - `cnt`==`expected_rate`: `run`<=1; if LOCK_COUNT==1, `locked`<=1.
    - Otherwise: `run`<=0, no error pulse (first interval is never an error).
    - Always -> TRACK.
  - TRACK: on each valid strobe, `measured_rate`<=`cnt` and `measured_valid` pulses.
    - Match: `run` increments, saturating at LOCK_COUNT; `locked`<=1 when `run` reaches LOCK_COUNT.
    - Mismatch: `run`<=0, `locked`<=0, `rate_error` pulses, `err_count` increments.
- Timeout:
  - Condition: in MEASURE or TRACK, `strobe_in` without `strobe` while `cnt`==2^WIDTH-1.
  - Response: `timeout` pulses, `locked`<=0, `run`<=0, `cnt`<=0, state -> IDLE. No `err_count` increment.
  - `cnt` never wraps.
- Illegal strobe (any state except reset/disabled):
  - `rate_error` pulses, `err_count` increments, `locked`<=0, `run`<=0.
  - `cnt` and state unchanged.
  - An illegal strobe is not a phase reference.
- `err_count` saturates at 2^ERRW-1. Only reset clears it.
- `expected_rate` is sampled only at valid strobes. A change mid-interval takes effect at the next comparison, with no special handling.
- Priority in one cycle: reset > !`enable` > valid strobe > timeout > count.

Decomposition:
- Shared package `strobe_pkg`:
  - State enum (IDLE, MEASURE, TRACK).
  - Default WIDTH and ERRW constants.
  - Rate-encoding note: divide ratio minus 1.
- One natural sub-module `sat_counter`:
  - Parameterised width, synchronous active-low clear, increment enable, saturating.
  - Used for `err_count` and the `run` counter.

Test Plan:
- `expected_rate`=3, `strobe_in` always high, `strobe` every 4th cycle:
  - `measured_rate`=3 with `measured_valid` one cycle after each strobe except the first.
  - `locked` rises one cycle after the 5th strobe (4 matching intervals in TRACK, counting the MEASURE match).
- Locked at rate 3, then one interval of 6 cycles:
  - `measured_rate`=5, `rate_error` pulses once, `locked` falls, `err_count`=1.
  - Relock after 4 further good intervals.
- `expected_rate`=0, `strobe`=`strobe_in`=1 every cycle:
  - `measured_rate`=0, `locked` after 5 strobes, no errors.
- `strobe_in` pulsing every 3rd cycle, `strobe` stopped after lock:
  - `timeout` pulse after 255 counted `strobe_in` pulses past `cnt`=255, i.e. at the 256th.
  - `locked`=0, state IDLE; the next strobe produces no `measured_valid`.
- `strobe` asserted with `strobe_in`=0 while locked:
  - `rate_error` pulse, `err_count`+1, `locked`=0, `cnt` continues undisturbed.
- Preload `err_count` to 65535 via 65535 illegal strobes (or force):
  - A further error leaves it at 65535.
  - `enable` low clears `locked` but holds `err_count`; `reset`=0 clears it to 0.
